// File: rtl/var_state_bank.sv
// Value/level store for NUM_VARS solver variables: decide, imply, analyze, backtrack.
// Optional `VAR_STATE_CNT_EN adds assigned_cnt_o (registered count of assigned vars).
module var_state_bank #(
    parameter int NUM_VARS         = 8,
    parameter int LEVEL_W          = 10,
    parameter int SCAN_LANES       = 2,
    parameter int WIDTH_VAR_STATES = 3 + LEVEL_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_VARS*3-1:0]                var_value_i,
    output logic [NUM_VARS*3-1:0]                var_value_o,
    input  logic [NUM_VARS-1:0]                  valid_from_decision_i,
    input  logic [LEVEL_W-1:0]                   cur_level_i,
    input  logic                                 apply_imply_i,
    output logic                                 find_imply_o,
    output logic                                 find_conflict_o,
    input  logic                                 apply_analyze_i,
    output logic [LEVEL_W-1:0]                   max_level_o,
    output logic                                 analyze_done_o,
    input  logic                                 apply_bkt_i,
    input  logic [LEVEL_W-1:0]                   bkt_lvl_i,
    output logic                                 bkt_done_o,
    input  logic [NUM_VARS-1:0]                  wr_states_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    output logic                                 busy_o
`ifdef VAR_STATE_CNT_EN
    ,
    output logic [$clog2(NUM_VARS+1)-1:0]        assigned_cnt_o
`endif
);

    localparam int STEPS = NUM_VARS / SCAN_LANES;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic {IDLE, ANALYZE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         val_q [NUM_VARS];
    logic [2:0]         val_d [NUM_VARS];
    logic [LEVEL_W-1:0] lvl_q [NUM_VARS];
    logic [LEVEL_W-1:0] lvl_d [NUM_VARS];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEVEL_W-1:0] acc_q, acc_d, max_d, lane_max;
    logic               imp_d, conf_d, done_d, bkt_d;
    logic [NUM_VARS-1:0] can_assign;
    logic               any_conf, dec_hit;

    always_comb begin
        can_assign = '0;
        any_conf   = 1'b0;
        for (int k = 0; k < NUM_VARS; k++) begin
            can_assign[k] = (val_q[k][1:0] == 2'b00) &&
                            (var_value_i[3*k +: 2] == 2'b01 ||
                             var_value_i[3*k +: 2] == 2'b10);
            if (var_value_i[3*k +: 2] == 2'b11 ||
                (val_q[k][1:0] != 2'b00 && var_value_i[3*k +: 2] != 2'b00 &&
                 var_value_i[3*k +: 2] != val_q[k][1:0]))
                any_conf = 1'b1;
        end
    end

    // Running max over the lanes of the current scan group.
    always_comb begin
        lane_max = acc_q;
        for (int k = 0; k < NUM_VARS; k++) begin
            if (k / SCAN_LANES == int'(cnt_q) && val_q[k][2] &&
                lvl_q[k] != cur_level_i && lvl_q[k] > lane_max)
                lane_max = lvl_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        max_d   = max_level_o;
        imp_d   = 1'b0;
        conf_d  = 1'b0;
        done_d  = 1'b0;
        bkt_d   = 1'b0;
        dec_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|wr_states_i) begin
                    for (int k = 0; k < NUM_VARS; k++) begin
                        if (wr_states_i[k]) begin
                            val_d[k] = vars_states_i[k*WIDTH_VAR_STATES+LEVEL_W +: 3];
                            lvl_d[k] = vars_states_i[k*WIDTH_VAR_STATES +: LEVEL_W];
                        end
                    end
                end else if (apply_bkt_i) begin
                    bkt_d = 1'b1;
                    for (int k = 0; k < NUM_VARS; k++) begin
                        if (lvl_q[k] > bkt_lvl_i) begin
                            val_d[k] = '0;
                            lvl_d[k] = '0;
                        end
                    end
                end else if (apply_analyze_i) begin
                    for (int k = 0; k < NUM_VARS; k++)
                        val_d[k][2] = var_value_i[3*k+2];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ANALYZE;
                end else if (apply_imply_i) begin
                    if (any_conf) begin
                        conf_d = 1'b1;
                    end else begin
                        imp_d = |can_assign;
                        for (int k = 0; k < NUM_VARS; k++) begin
                            if (can_assign[k]) begin
                                val_d[k] = {1'b0, var_value_i[3*k +: 2]};
                                lvl_d[k] = cur_level_i;
                            end
                        end
                    end
                end else if (|valid_from_decision_i) begin
                    for (int k = 0; k < NUM_VARS; k++) begin
                        if (valid_from_decision_i[k] && !dec_hit) begin
                            dec_hit  = 1'b1;
                            val_d[k] = {1'b0, var_value_i[3*k +: 2]};
                            lvl_d[k] = cur_level_i;
                        end
                    end
                end
            end
            ANALYZE: begin
                acc_d = lane_max;
                cnt_d = cnt_q + CNT_W'(1);
                if (int'(cnt_q) == STEPS - 1) begin
                    max_d   = lane_max;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    for (int k = 0; k < NUM_VARS; k++)
                        val_d[k][2] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_VARS; k++) begin
                val_q[k] <= '0;
                lvl_q[k] <= '0;
            end
            cnt_q           <= '0;
            acc_q           <= '0;
            max_level_o     <= '0;
            find_imply_o    <= 1'b0;
            find_conflict_o <= 1'b0;
            analyze_done_o  <= 1'b0;
            bkt_done_o      <= 1'b0;
        end else begin
            val_q           <= val_d;
            lvl_q           <= lvl_d;
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            max_level_o     <= max_d;
            find_imply_o    <= imp_d;
            find_conflict_o <= conf_d;
            analyze_done_o  <= done_d;
            bkt_done_o      <= bkt_d;
        end
    end

    assign busy_o = (state_q == ANALYZE);

    always_comb begin
        for (int k = 0; k < NUM_VARS; k++) begin
            var_value_o[3*k +: 3] = val_q[k];
            vars_states_o[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] = {val_q[k], lvl_q[k]};
        end
    end

`ifdef VAR_STATE_CNT_EN
    localparam int AC_W = $clog2(NUM_VARS + 1);
    logic [AC_W-1:0] cnt_now;

    always_comb begin
        cnt_now = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            if (val_q[k][1:0] == 2'b01 || val_q[k][1:0] == 2'b10)
                cnt_now = cnt_now + AC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            assigned_cnt_o <= '0;
        end else begin
            assigned_cnt_o <= cnt_now;
        end
    end
`endif

endmodule

// File: tb/tb_var_state_bank.sv
// Directed bench for var_state_bank: load, decide, imply, conflict,
// analyze latency/result, backtrack, busy lockout and mid-scan reset.
module tb_var_state_bank;

    localparam int N  = 8;
    localparam int LW = 10;
    localparam int W  = 3 + LW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*3-1:0]  var_value_i = '0;
    logic [N*3-1:0]  var_value_o;
    logic [N-1:0]    valid_from_decision_i = '0;
    logic [LW-1:0]   cur_level_i = '0;
    logic            apply_imply_i = 1'b0;
    logic            find_imply_o;
    logic            find_conflict_o;
    logic            apply_analyze_i = 1'b0;
    logic [LW-1:0]   max_level_o;
    logic            analyze_done_o;
    logic            apply_bkt_i = 1'b0;
    logic [LW-1:0]   bkt_lvl_i = '0;
    logic            bkt_done_o;
    logic [N-1:0]    wr_states_i = '0;
    logic [W*N-1:0]  vars_states_i = '0;
    logic [W*N-1:0]  vars_states_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_s [N];
    int busy_cnt, done_at, done_n;
    logic [LW-1:0] got_max;

    var_state_bank dut (
        .clk                   (clk),
        .rst                   (rst),
        .var_value_i           (var_value_i),
        .var_value_o           (var_value_o),
        .valid_from_decision_i (valid_from_decision_i),
        .cur_level_i           (cur_level_i),
        .apply_imply_i         (apply_imply_i),
        .find_imply_o          (find_imply_o),
        .find_conflict_o       (find_conflict_o),
        .apply_analyze_i       (apply_analyze_i),
        .max_level_o           (max_level_o),
        .analyze_done_o        (analyze_done_o),
        .apply_bkt_i           (apply_bkt_i),
        .bkt_lvl_i             (bkt_lvl_i),
        .bkt_done_o            (bkt_done_o),
        .wr_states_i           (wr_states_i),
        .vars_states_i         (vars_states_i),
        .vars_states_o         (vars_states_o),
        .busy_o                (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W*N-1:0] packed_exp();
        logic [W*N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = exp_s[k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int k = 0; k < N; k++) exp_s[k] = '0;
    endtask

    task automatic load_exp();
        vars_states_i = packed_exp();
        wr_states_i   = '1;
        tick();
        wr_states_i   = '0;
        vars_states_i = '0;
    endtask

    initial begin
        clear_exp();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_states", vars_states_o, '0);
        chk("rst_values", var_value_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_max", max_level_o, '0);
        chk("rst_pulses", {find_imply_o, find_conflict_o,
                           analyze_done_o, bkt_done_o}, 4'b0);
        rst = 1'b1;
        tick();

        // single-var load
        exp_s[3] = {3'b010, 10'd5};
        vars_states_i = packed_exp();
        wr_states_i   = 8'b0000_1000;
        tick();
        wr_states_i   = '0;
        vars_states_i = '0;
        chk("load_var3", vars_states_o, packed_exp());
        chk("load_val3", var_value_o[11:9], 3'b010);

        // decision then imply
        var_value_i[2:0]      = 3'b001;
        cur_level_i           = 10'd3;
        valid_from_decision_i = 8'h01;
        tick();
        valid_from_decision_i = '0;
        var_value_i           = '0;
        exp_s[0] = {3'b001, 10'd3};
        chk("decide_var0", vars_states_o, packed_exp());
        var_value_i[5:3] = 3'b010;
        apply_imply_i    = 1'b1;
        tick();
        apply_imply_i    = 1'b0;
        var_value_i      = '0;
        exp_s[1] = {3'b010, 10'd3};
        chk("imply_states", vars_states_o, packed_exp());
        chk("imply_pulse", find_imply_o, 1'b1);
        chk("imply_noconf", find_conflict_o, 1'b0);
        tick();
        chk("imply_pulse_end", find_imply_o, 1'b0);

        // opposite value on assigned var
        var_value_i[2:0] = 3'b010;
        apply_imply_i    = 1'b1;
        tick();
        apply_imply_i    = 1'b0;
        var_value_i      = '0;
        chk("conf_pulse", find_conflict_o, 1'b1);
        chk("conf_noimply", find_imply_o, 1'b0);
        chk("conf_states", vars_states_o, packed_exp());
        tick();
        chk("conf_pulse_end", find_conflict_o, 1'b0);

        // illegal 11 on an unassigned var blocks the whole imply
        var_value_i[23:21] = 3'b011;
        var_value_i[8:6]   = 3'b001;
        apply_imply_i      = 1'b1;
        tick();
        apply_imply_i      = 1'b0;
        var_value_i        = '0;
        chk("conf11_pulse", find_conflict_o, 1'b1);
        chk("conf11_states", vars_states_o, packed_exp());

        // load outranks decision in the same cycle
        vars_states_i[7*W +: W] = {3'b001, 10'd9};
        wr_states_i             = 8'h80;
        var_value_i[20:18]      = 3'b010;
        valid_from_decision_i   = 8'h40;
        tick();
        wr_states_i = '0;
        vars_states_i = '0;
        valid_from_decision_i = '0;
        var_value_i = '0;
        exp_s[7] = {3'b001, 10'd9};
        chk("prio_load", vars_states_o, packed_exp());

        // multi-hot decision: lowest index wins
        var_value_i[17:15]    = 3'b001;
        var_value_i[20:18]    = 3'b010;
        cur_level_i           = 10'd8;
        valid_from_decision_i = 8'b0110_0000;
        tick();
        valid_from_decision_i = '0;
        var_value_i = '0;
        exp_s[5] = {3'b001, 10'd8};
        chk("multi_decide", vars_states_o, packed_exp());

        // analysis scan
        clear_exp();
        exp_s[1] = {3'b010, 10'd2};
        exp_s[2] = {3'b001, 10'd4};
        exp_s[5] = {3'b010, 10'd6};
        load_exp();
        cur_level_i     = 10'd6;
        var_value_i[5]  = 1'b1;
        var_value_i[8]  = 1'b1;
        var_value_i[17] = 1'b1;
        apply_analyze_i = 1'b1;
        tick();
        apply_analyze_i = 1'b0;
        var_value_i     = '0;
        busy_cnt = 0;
        done_at  = 0;
        done_n   = 0;
        got_max  = '0;
        for (int i = 1; i <= 10; i++) begin
            if (busy_o) busy_cnt++;
            if (analyze_done_o) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = i;
                    got_max = max_level_o;
                end
            end
            apply_bkt_i = (i == 2);
            bkt_lvl_i   = '0;
            tick();
        end
        apply_bkt_i = 1'b0;
        chk("an_busy_cycles", busy_cnt, 4);
        chk("an_done_cycle", done_at, 5);
        chk("an_done_once", done_n, 1);
        chk("an_max", got_max, 10'd4);
        chk("an_max_hold", max_level_o, 10'd4);
        chk("an_marks_clr", vars_states_o, packed_exp());

        // backtrack
        clear_exp();
        exp_s[0] = {3'b010, 10'd1};
        exp_s[1] = {3'b001, 10'd3};
        exp_s[2] = {3'b010, 10'd5};
        exp_s[3] = {3'b001, 10'd7};
        load_exp();
        bkt_lvl_i   = 10'd3;
        apply_bkt_i = 1'b1;
        tick();
        apply_bkt_i = 1'b0;
        exp_s[2] = '0;
        exp_s[3] = '0;
        chk("bkt_states", vars_states_o, packed_exp());
        chk("bkt_done", bkt_done_o, 1'b1);
        tick();
        chk("bkt_done_end", bkt_done_o, 1'b0);
        apply_bkt_i = 1'b1;
        tick();
        apply_bkt_i = 1'b0;
        chk("bkt_noop_states", vars_states_o, packed_exp());
        chk("bkt_noop_done", bkt_done_o, 1'b1);

        // reset in the middle of a scan
        var_value_i[2]  = 1'b1;
        apply_analyze_i = 1'b1;
        tick();
        apply_analyze_i = 1'b0;
        var_value_i     = '0;
        tick();
        chk("mid_busy", busy_o, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_states", vars_states_o, '0);
        chk("mid_rst_max", max_level_o, '0);
        #2 rst = 1'b1;
        done_n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (analyze_done_o) done_n++;
        end
        chk("mid_no_stale", done_n, 0);
        apply_analyze_i = 1'b1;
        tick();
        apply_analyze_i = 1'b0;
        done_n  = 0;
        got_max = '1;
        for (int i = 0; i < 10; i++) begin
            if (analyze_done_o) begin
                done_n++;
                got_max = max_level_o;
            end
            tick();
        end
        chk("nomark_done", done_n, 1);
        chk("nomark_max", got_max, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
